// File: rtl/div_pkg.sv
// Shared types for the sequential non-restoring divider.
// Holds the FSM state encoding and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter width for an N-step iteration loop: $clog2(N+1)
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step: shift in the next dividend bit, then
// subtract |M| when P >= 0 or add |M| when P < 0, using a ripple adder.
// Ports: p_i (N+1 partial remainder), bit_i (shift-in), m_i (|M|),
//        p_o (next partial remainder), q_o (quotient bit = ~sign(p_o)).
module nr_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   p_i,
    input  logic         bit_i,
    input  logic [N-1:0] m_i,
    output logic [N:0]   p_o,
    output logic         q_o
);

    logic [N:0] sh;
    logic [N:0] b;
    logic [N:0] s;
    logic       sub;
    logic       c;

    always_comb begin
        sub = ~p_i[N];
        sh  = {p_i[N-1:0], bit_i};
        b   = sub ? ~{1'b0, m_i} : {1'b0, m_i};
        c   = sub;
        s   = '0;
        for (int i = 0; i <= N; i++) begin
            s[i] = sh[i] ^ b[i] ^ c;
            c    = (sh[i] & b[i]) | (c & (sh[i] ^ b[i]));
        end
    end

    assign p_o = s;
    assign q_o = ~s[N];

endmodule

// File: rtl/seq_nr_divider.sv
// Multi-cycle non-restoring divider, one add/sub step per clock.
// Ports: clk, rst_n (async low), start/signed_op/D/M in;
//        ready, done (1-cycle pulse), Q, R, dz, ovf out (held).
module seq_nr_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] D,
    input  logic [N-1:0] M,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         dz,
    output logic         ovf
);

    localparam int CNT_W = cnt_w(N);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N:0]       p_q, p_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     d_q, d_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             opdz_q, opdz_d;
    logic             opovf_q, opovf_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     r_q, r_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [N:0]       p_step;
    logic             q_bit;
    logic [N-1:0]     d_mag;
    logic [N-1:0]     m_mag;
    logic [N-1:0]     r_mag;

    nr_div_step #(.N(N)) u_step (
        .p_i   (p_q),
        .bit_i (a_q[N-1]),
        .m_i   (m_q),
        .p_o   (p_step),
        .q_o   (q_bit)
    );

    // |-2^(N-1)| = 2^(N-1) still fits as an N-bit unsigned magnitude
    assign d_mag = (signed_op && D[N-1]) ? -D : D;
    assign m_mag = (signed_op && M[N-1]) ? -M : M;

    // Final restore of a negative remainder; result lies in [0, |M|)
    assign r_mag = p_q[N] ? (p_q[N-1:0] + m_q) : p_q[N-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        m_d     = m_q;
        d_d     = d_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        opdz_d  = opdz_q;
        opovf_d = opovf_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Zero divisor skips the iteration loop entirely
                    state_d = (M == '0) ? CORR : ITER;
                    cnt_d   = '0;
                    p_d     = '0;
                    a_d     = d_mag;
                    m_d     = m_mag;
                    d_d     = D;
                    negq_d  = signed_op && (D[N-1] ^ M[N-1]);
                    negr_d  = signed_op && D[N-1];
                    opdz_d  = (M == '0);
                    opovf_d = signed_op
                            && (D == {1'b1, {(N-1){1'b0}}})
                            && (M == '1);
                end
            end
            ITER: begin
                p_d   = p_step;
                a_d   = {a_q[N-2:0], q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                state_d = DONE;
                if (opdz_q) begin
                    q_d   = '1;
                    r_d   = d_q;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    // Overflow case wraps naturally: both negative, Q = 2^(N-1)
                    q_d   = negq_q ? -a_q : a_q;
                    r_d   = negr_q ? -r_mag : r_mag;
                    dz_d  = 1'b0;
                    ovf_d = opovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            m_q     <= '0;
            d_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            opdz_q  <= 1'b0;
            opovf_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            m_q     <= m_d;
            d_q     <= d_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            opdz_q  <= opdz_d;
            opovf_q <= opovf_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign Q     = q_q;
    assign R     = r_q;
    assign dz    = dz_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed bench for seq_nr_divider at N=4 and N=8.
// Covers reset, latency, back-to-back, signed, dz, ovf, abort, N=4 sweep.
module tb_seq_nr_divider;

    logic       clk;
    logic       rst_n;

    logic       s4, sg4;
    logic [3:0] d4, m4;
    logic       rdy4, dn4, dz4, ov4;
    logic [3:0] q4, r4;

    logic       s8, sg8;
    logic [7:0] d8, m8;
    logic       rdy8, dn8, dz8, ov8;
    logic [7:0] q8, r8;

    int checks;
    int errors;

    seq_nr_divider #(.N(4)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s4),
        .signed_op (sg4),
        .D         (d4),
        .M         (m4),
        .ready     (rdy4),
        .done      (dn4),
        .Q         (q4),
        .R         (r4),
        .dz        (dz4),
        .ovf       (ov4)
    );

    seq_nr_divider #(.N(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s8),
        .signed_op (sg8),
        .D         (d8),
        .M         (m8),
        .ready     (rdy8),
        .done      (dn8),
        .Q         (q8),
        .R         (r8),
        .dz        (dz8),
        .ovf       (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx4(input logic [3:0] v, input logic s);
        if (s && v[3]) return int'(v) - 16;
        return int'(v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // lat = edges from the accepting edge up to the one raising done
    task automatic run4(input logic [3:0] d, input logic [3:0] m,
                        input logic sg, output int lat);
        s4 = 1'b1; d4 = d; m4 = m; sg4 = sg;
        tick();
        s4 = 1'b0;
        lat = 1;
        while (!dn4 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] d, input logic [7:0] m,
                        input logic sg, output int lat);
        s8 = 1'b1; d8 = d; m8 = m; sg8 = sg;
        tick();
        s8 = 1'b0;
        lat = 1;
        while (!dn8 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (rdy8 !== 1'b1) begin
            errors++; $display("FAIL rst_ready8 got %b exp 1", rdy8);
        end
        checks++;
        if (dn8 !== 1'b0) begin
            errors++; $display("FAIL rst_done8 got %b exp 0", dn8);
        end
        checks++;
        if (q8 !== 8'h00 || r8 !== 8'h00) begin
            errors++; $display("FAIL rst_qr8 got %h/%h exp 00/00", q8, r8);
        end
        checks++;
        if (dz8 !== 1'b0 || ov8 !== 1'b0) begin
            errors++; $display("FAIL rst_flags8 got %b%b exp 00", dz8, ov8);
        end
        checks++;
        if (rdy4 !== 1'b1 || dn4 !== 1'b0 || q4 !== 4'h0 || r4 !== 4'h0) begin
            errors++;
            $display("FAIL rst_4 got rdy=%b dn=%b q=%h r=%h exp 1 0 0 0",
                     rdy4, dn4, q4, r4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned4();
        int lat;
        run4(4'd12, 4'd5, 1'b0, lat);
        checks++;
        if (lat !== 6 || dn4 !== 1'b1) begin
            errors++; $display("FAIL u4_latency got %0d exp 6", lat);
        end
        checks++;
        if (q4 !== 4'd2 || r4 !== 4'd2 || dz4 !== 1'b0) begin
            errors++;
            $display("FAIL u4_12div5 got q=%h r=%h dz=%b exp 2 2 0",
                     q4, r4, dz4);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run4(4'd7, 4'd2, 1'b0, lat);
        checks++;
        if (q4 !== 4'd3 || r4 !== 4'd1 || rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got q=%h r=%h rdy=%b exp 3 1 1",
                     q4, r4, rdy4);
        end
        run4(4'd9, 4'd4, 1'b0, lat);
        checks++;
        if (q4 !== 4'd2 || r4 !== 4'd1 || lat !== 6) begin
            errors++;
            $display("FAIL b2b_second got q=%h r=%h lat=%0d exp 2 1 6",
                     q4, r4, lat);
        end
    endtask

    task automatic test_signed4();
        int lat;
        run4(4'b1001, 4'd2, 1'b1, lat);
        checks++;
        if (q4 !== 4'b1101 || r4 !== 4'b1111 || ov4 !== 1'b0) begin
            errors++;
            $display("FAIL s4_m7div2 got q=%b r=%b ovf=%b exp 1101 1111 0",
                     q4, r4, ov4);
        end
        run4(4'd7, 4'b1110, 1'b1, lat);
        checks++;
        if (q4 !== 4'b1101 || r4 !== 4'b0001) begin
            errors++;
            $display("FAIL s4_7divm2 got q=%b r=%b exp 1101 0001", q4, r4);
        end
    endtask

    task automatic test_div_zero8();
        int lat;
        run8(8'h5A, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 2 || dn8 !== 1'b1) begin
            errors++; $display("FAIL dz_latency got %0d exp 2", lat);
        end
        checks++;
        if (dz8 !== 1'b1 || ov8 !== 1'b0 || q8 !== 8'hFF || r8 !== 8'h5A) begin
            errors++;
            $display("FAIL dz_result got dz=%b ovf=%b q=%h r=%h exp 1 0 FF 5A",
                     dz8, ov8, q8, r8);
        end
    endtask

    task automatic test_overflow8();
        int lat;
        s8 = 1'b1; d8 = 8'h80; m8 = 8'hFF; sg8 = 1'b1;
        tick();
        s8 = 1'b0;
        lat = 1;
        repeat (2) begin
            tick();
            lat++;
        end
        s8 = 1'b1; d8 = 8'h10; m8 = 8'h03; sg8 = 1'b0;
        tick();
        lat++;
        s8 = 1'b0;
        while (!dn8 && lat < 30) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 10) begin
            errors++; $display("FAIL ovf_latency got %0d exp 10", lat);
        end
        checks++;
        if (ov8 !== 1'b1 || dz8 !== 1'b0 || q8 !== 8'h80 || r8 !== 8'h00) begin
            errors++;
            $display("FAIL ovf_result got ovf=%b dz=%b q=%h r=%h exp 1 0 80 00",
                     ov8, dz8, q8, r8);
        end
    endtask

    task automatic test_reset_mid();
        bit saw;
        s8 = 1'b1; d8 = 8'd100; m8 = 8'd7; sg8 = 1'b0;
        tick();
        s8 = 1'b0;
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy8 !== 1'b1 || dn8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctl got rdy=%b dn=%b exp 1 0", rdy8, dn8);
        end
        checks++;
        if (q8 !== 8'h00 || r8 !== 8'h00 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_qr got q=%h r=%h ovf=%b exp 00 00 0",
                     q8, r8, ov8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            tick();
            if (dn8 !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_nodone got done_seen=%b rdy=%b exp 0 1",
                     saw, rdy8);
        end
    endtask

    task automatic test_sweep4();
        int lat, dv, mv, qv, rv;
        bit ok;
        logic [3:0] dl, ml;
        logic sgb;
        for (int sg = 0; sg < 2; sg++) begin
            for (int di = 0; di < 16; di++) begin
                for (int mi = 0; mi < 16; mi++) begin
                    dl  = 4'(di);
                    ml  = 4'(mi);
                    sgb = 1'(sg);
                    run4(dl, ml, sgb, lat);
                    if (mi == 0) begin
                        ok = dn4 && dz4 && !ov4 && q4 == 4'hF
                             && r4 == dl && lat == 2;
                    end else if (sg == 1 && di == 8 && mi == 15) begin
                        ok = dn4 && ov4 && !dz4 && q4 == 4'h8
                             && r4 == 4'h0 && lat == 6;
                    end else begin
                        dv = sx4(dl, sgb);
                        mv = sx4(ml, sgb);
                        qv = sx4(q4, sgb);
                        rv = sx4(r4, sgb);
                        ok = dn4 && !dz4 && !ov4 && lat == 6
                             && dv == qv * mv + rv
                             && iabs(rv) < iabs(mv)
                             && (rv == 0 || ((rv < 0) == (dv < 0)));
                    end
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL sweep sg=%0d D=%h M=%h got q=%h r=%h dz=%b ovf=%b lat=%0d",
                                 sg, dl, ml, q4, r4, dz4, ov4, lat);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        s4 = 1'b0; sg4 = 1'b0; d4 = '0; m4 = '0;
        s8 = 1'b0; sg8 = 1'b0; d8 = '0; m8 = '0;
        test_reset();
        test_unsigned4();
        test_back_to_back();
        test_signed4();
        test_div_zero8();
        test_overflow8();
        test_reset_mid();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
